// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational RV32I ALU between an execute-stage
// requester (port 0) and an auxiliary address/PC requester (port 1). One
// transaction is in flight at a time: IDLE (accept) -> EXEC (ALU driven) ->
// RESP (result held until the granted port consumes it).
module alu_share_arbiter #(
  parameter int TAG_W     = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [6:0]       req0_opcode,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [31:0]      req0_srca,
  input  logic [31:0]      req0_srcb,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [6:0]       req1_opcode,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [31:0]      req1_srca,
  input  logic [31:0]      req1_srcb,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp_result,
  output logic             resp_branch,
  output logic [TAG_W-1:0] resp_tag,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_funct3,
  output logic [6:0]       alu_funct7,
  output logic [31:0]      alu_srca,
  output logic [31:0]      alu_srcb,
  input  logic [31:0]      alu_result,
  input  logic             alu_branch,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q;
  logic               grant_q;       // port owning the in-flight transaction
  logic               last_grant_q;  // port granted at the most recent acceptance
  logic [TAG_W-1:0]   tag_q;
  logic               resp0_valid_q;
  logic               resp1_valid_q;
  logic [31:0]        resp_result_q;
  logic               resp_branch_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic [6:0]         alu_opcode_q;
  logic [2:0]         alu_funct3_q;
  logic [6:0]         alu_funct7_q;
  logic [31:0]        alu_srca_q;
  logic [31:0]        alu_srcb_q;
  logic               sel0_d;
  logic               sel1_d;
  logic               resp_take;

  // Grant decision for this cycle; only meaningful while IDLE.
  always_comb begin
    sel0_d = 1'b0;
    sel1_d = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && req1_valid) begin
        if ((PRIO_MODE == 1) || last_grant_q) sel0_d = 1'b1;
        else                                  sel1_d = 1'b1;
      end else begin
        sel0_d = req0_valid;
        sel1_d = req1_valid;
      end
    end
  end

  assign req0_ready = sel0_d & ~rst;
  assign req1_ready = sel1_d & ~rst;
  assign resp_take  = grant_q ? resp1_ready : resp0_ready;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      tag_q         <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_result_q <= '0;
      resp_branch_q <= 1'b0;
      resp_tag_q    <= '0;
      alu_opcode_q  <= '0;
      alu_funct3_q  <= '0;
      alu_funct7_q  <= '0;
      alu_srca_q    <= '0;
      alu_srcb_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel0_d || sel1_d) begin
            alu_opcode_q <= sel1_d ? req1_opcode : req0_opcode;
            alu_funct3_q <= sel1_d ? req1_funct3 : req0_funct3;
            alu_funct7_q <= sel1_d ? req1_funct7 : req0_funct7;
            alu_srca_q   <= sel1_d ? req1_srca   : req0_srca;
            alu_srcb_q   <= sel1_d ? req1_srcb   : req0_srcb;
            tag_q        <= sel1_d ? req1_tag    : req0_tag;
            grant_q      <= sel1_d;
            last_grant_q <= sel1_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          resp_result_q <= alu_result;
          resp_branch_q <= alu_branch;
          resp_tag_q    <= tag_q;
          resp0_valid_q <= ~grant_q;
          resp1_valid_q <= grant_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (resp_take) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_result = resp_result_q;
  assign resp_branch = resp_branch_q;
  assign resp_tag    = resp_tag_q;
  assign alu_opcode  = alu_opcode_q;
  assign alu_funct3  = alu_funct3_q;
  assign alu_funct7  = alu_funct7_q;
  assign alu_srca    = alu_srca_q;
  assign alu_srcb    = alu_srcb_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a table of ALU transactions run through a
// scoreboard, plus directed sequences for arbitration, stalls and reset.
module tb_alu_share_arbiter;

  typedef struct {
    bit          port;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        br;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_result;
  logic        resp_branch;
  logic [3:0]  resp_tag;
  logic [6:0]  alu_opcode, alu_funct7;
  logic [2:0]  alu_funct3;
  logic [31:0] alu_srca, alu_srcb, alu_result;
  logic        alu_branch, busy;

  logic        p_req0_ready, p_req1_ready, p_resp0_valid, p_resp1_valid;
  logic [31:0] p_resp_result, p_alu_srca, p_alu_srcb, p_alu_result;
  logic        p_resp_branch, p_alu_branch, p_busy;
  logic [3:0]  p_resp_tag;
  logic [6:0]  p_alu_opcode, p_alu_funct7;
  logic [2:0]  p_alu_funct3;

  vec_t cur0, cur1;
  vec_t tab [10];
  vec_t sb [$];
  bit   glog [$];
  int   gcyc [$];
  int   checks = 0, errors = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   prev_rv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32I ALU subset driving both DUT instances.
  function automatic logic [32:0] alu_f(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        br;
    r  = '0;
    br = 1'b0;
    case (op)
      7'b0110011: case (f3)
        3'b000:  r = f7[5] ? a - b : a + b;
        3'b100:  r = a ^ b;
        3'b110:  r = a | b;
        3'b111:  r = a & b;
        default: r = '0;
      endcase
      7'b0010011: r = a + b;
      7'b1100011: begin
        r = a - b;
        case (f3)
          3'b000:  br = (a == b);
          3'b001:  br = (a != b);
          3'b100:  br = ($signed(a) < $signed(b));
          default: br = 1'b0;
        endcase
      end
      7'b1101111: begin r = a + 32'd4; br = 1'b1; end
      default: r = '0;
    endcase
    return {br, r};
  endfunction

  assign {alu_branch, alu_result}     = alu_f(alu_opcode, alu_funct3, alu_funct7, alu_srca, alu_srcb);
  assign {p_alu_branch, p_alu_result} = alu_f(p_alu_opcode, p_alu_funct3, p_alu_funct7, p_alu_srca, p_alu_srcb);

  alu_share_arbiter #(.TAG_W(4), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(cur0.op), .req0_funct3(cur0.f3),
    .req0_funct7(cur0.f7), .req0_srca(cur0.a), .req0_srcb(cur0.b), .req0_tag(cur0.tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(cur1.op), .req1_funct3(cur1.f3),
    .req1_funct7(cur1.f7), .req1_srca(cur1.a), .req1_srcb(cur1.b), .req1_tag(cur1.tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_branch(resp_branch), .resp_tag(resp_tag),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_result(alu_result), .alu_branch(alu_branch), .busy(busy)
  );

  alu_share_arbiter #(.TAG_W(4), .PRIO_MODE(1)) dut_p (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_opcode(cur0.op), .req0_funct3(cur0.f3),
    .req0_funct7(cur0.f7), .req0_srca(cur0.a), .req0_srcb(cur0.b), .req0_tag(cur0.tag),
    .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_opcode(cur1.op), .req1_funct3(cur1.f3),
    .req1_funct7(cur1.f7), .req1_srca(cur1.a), .req1_srcb(cur1.b), .req1_tag(cur1.tag),
    .resp0_valid(p_resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(p_resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(p_resp_result), .resp_branch(p_resp_branch), .resp_tag(p_resp_tag),
    .alu_opcode(p_alu_opcode), .alu_funct3(p_alu_funct3), .alu_funct7(p_alu_funct7),
    .alu_srca(p_alu_srca), .alu_srcb(p_alu_srcb), .alu_result(p_alu_result), .alu_branch(p_alu_branch), .busy(p_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout (t=%0t)", name, $time);
  endtask

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) begin
        sb.push_back(cur0); glog.push_back(1'b0); gcyc.push_back(cyc); acc_cyc = cyc;
      end else if (req1_valid && req1_ready) begin
        sb.push_back(cur1); glog.push_back(1'b1); gcyc.push_back(cyc); acc_cyc = cyc;
      end
      if ((resp0_valid || resp1_valid) && !prev_rv) chk("latency", 32'(cyc - acc_cyc), 32'd2);
      prev_rv = resp0_valid || resp1_valid;
      if (resp0_valid && resp1_valid) chk("both_resp_valid", 32'd1, 32'd0);
      if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          vec_t e;
          e = sb.pop_front();
          chk("resp_port",   {31'd0, resp1_valid}, {31'd0, e.port});
          chk("resp_result", resp_result, e.res);
          chk("resp_branch", {31'd0, resp_branch}, {31'd0, e.br});
          chk("resp_tag",    {28'd0, resp_tag}, {28'd0, e.tag});
        end
      end
    end else begin
      prev_rv = 1'b0;
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    fail_now("wait_response");
    sb.delete();
  endtask

  task automatic wait_accept(input bit port);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) return;
    end
    fail_now("wait_accept");
  endtask

  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    if (v.port) begin cur1 = v; req1_valid = 1'b1; end
    else        begin cur0 = v; req0_valid = 1'b1; end
    wait_accept(v.port);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_empty();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); glog.delete(); gcyc.delete();
  endtask

  initial begin
    int p_acc0;
    tab[0] = '{1'b0, 7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0};
    tab[1] = '{1'b1, 7'b1100011, 3'b000, 7'b0000000, 32'd9, 32'd9, 4'd5, 32'd0, 1'b1};
    tab[2] = '{1'b0, 7'b0110011, 3'b000, 7'b0100000, 32'd3, 32'd5, 4'd6, 32'hFFFFFFFE, 1'b0};
    tab[3] = '{1'b1, 7'b0110011, 3'b111, 7'b0000000, 32'hF0F0FFFF, 32'h0FF01234, 4'd9, 32'h00F01234, 1'b0};
    tab[4] = '{1'b0, 7'b0110011, 3'b110, 7'b0000000, 32'h000000F0, 32'h0000000F, 4'hA, 32'h000000FF, 1'b0};
    tab[5] = '{1'b1, 7'b1100011, 3'b001, 7'b0000000, 32'd1, 32'd2, 4'hF, 32'hFFFFFFFF, 1'b1};
    tab[6] = '{1'b0, 7'b1101111, 3'b000, 7'b0000000, 32'h1000, 32'h20, 4'd1, 32'h1004, 1'b1};
    tab[7] = '{1'b1, 7'b1100011, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1, 4'd2, 32'hFFFFFFFE, 1'b1};
    tab[8] = '{1'b0, 7'b1100011, 3'b000, 7'b0000000, 32'd1, 32'd2, 4'd4, 32'hFFFFFFFF, 1'b0};
    tab[9] = '{1'b1, 7'b0110011, 3'b100, 7'b0000000, 32'hAAAA5555, 32'hFFFF0000, 4'd7, 32'h55555555, 1'b0};
    cur0 = tab[0];
    cur1 = tab[1];

    // Reset: ready suppressed while rst is high, then all outputs at reset values.
    repeat (2) @(posedge clk);
    #1 req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_branch", {31'd0, resp_branch}, 32'd0);
    chk("rst_tag", {28'd0, resp_tag}, 32'd0);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Table of single transactions with responses consumed immediately.
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    for (int i = 0; i < 10; i++) run_txn(tab[i]);

    // Both ports valid every cycle: round-robin on dut, port 0 only on dut_p.
    do_reset();
    cur0 = tab[0];
    cur1 = tab[1];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    p_acc0 = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("prio_req1_ready", {31'd0, p_req1_ready}, 32'd0);
      if (p_req0_ready) p_acc0++;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_grant_count", glog.size(), 32'd6);
    for (int i = 0; i < glog.size(); i++) chk("rr_grant_order", {31'd0, glog[i]}, 32'(i % 2));
    for (int i = 1; i < gcyc.size(); i++) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    chk("prio_port0_accepts", 32'(p_acc0), 32'(glog.size()));
    wait_empty();

    // Port 1 branch response stalled by resp1_ready=0 for 5 cycles.
    resp1_ready = 1'b0;
    @(posedge clk); #1;
    cur1 = tab[1];
    req1_valid = 1'b1;
    wait_accept(1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    cur0 = tab[0];
    req0_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (!resp1_valid && n < 10) begin @(negedge clk); n++; end
      if (!resp1_valid) fail_now("stall_resp1_valid");
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, resp1_valid}, 32'd1);
      chk("stall_result", resp_result, 32'd0);
      chk("stall_branch", {31'd0, resp_branch}, 32'd1);
      chk("stall_tag", {28'd0, resp_tag}, 32'd5);
      chk("stall_no_accept", {31'd0, req0_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    resp1_ready = 1'b1;
    wait_empty();

    // Reset while port 0 transaction is in EXEC: dropped, port 0 wins next contest.
    @(posedge clk); #1;
    cur0 = tab[0];
    req0_valid = 1'b1;
    wait_accept(1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_result", resp_result, 32'd0);
    chk("mid_rst_alu_srca", alu_srca, 32'd0);
    chk("mid_rst_tag", {28'd0, resp_tag}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_resp0_late", {31'd0, resp0_valid}, 32'd0);
    cur1 = tab[3];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_win0", {31'd0, req0_ready}, 32'd1);
    chk("mid_rst_lose1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_empty();

    // Subtract, then idle: ALU operands hold and no response appears.
    run_txn(tab[2]);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_alu_srca", alu_srca, 32'd3);
      chk("idle_resp_valid", {31'd0, resp0_valid | resp1_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
